wxga_line_fetch_ctrl: RTL and testbench

Scanline fetch scheduler for the WXGA 1366x768 video path. Uses the sync generator's end-of-line and end-of-frame strobes to request one scanline of pixel data per visible line from the memory port, in bursts with a req/ack handshake. Tracks returned data, advances the frame-buffer address by a line stride, and flags underrun when a line fetch has not finished before the next line starts. Sits between the sync generator and the memory arbiter, in front of the line buffer.

---
 rtl/wxga_line_fetch_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_wxga_line_fetch_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wxga_line_fetch_ctrl.sv
// wxga_line_fetch_ctrl
// Scanline fetch scheduler for the 1366x768 video path. On each end-of-line
// strobe that precedes a display line, it requests one scanline from the
// memory arbiter as a series of bursts. It counts returned words, steps the
// frame-buffer address by the line stride, and raises a sticky underrun flag
// when a new line arrives before the previous fetch has finished.
module wxga_line_fetch_ctrl #(
  parameter logic [31:0] pBaseAddr   = 32'h0000_0000,
  parameter int unsigned pLineWords  = 342,
  parameter int unsigned pBurstLen   = 16,
  parameter int unsigned pWordBytes  = 8,
  parameter int unsigned pLineStride = 2736
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        eol,
  input  logic        eof,
  input  logic        next_vis,
  output logic        req,
  input  logic        ack,
  output logic [31:0] addr,
  output logic [4:0]  blen,
  input  logic        rd_vld,
  output logic        busy,
  output logic        line_done,
  output logic        underrun,
  input  logic        clr_underrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [11:0] LINE_WORDS = 12'(pLineWords);
  localparam logic [4:0]  BURST_MAX  = 5'(pBurstLen);
  localparam logic [31:0] STRIDE     = 32'(pLineStride);
  localparam logic [31:0] WORD_BYTES = 32'(pWordBytes);

  // Burst size for the words still to request: full bursts, then the tail.
  function automatic logic [4:0] burst_len_f(input logic [11:0] rem);
    logic [4:0] len;
    if (rem >= {7'd0, BURST_MAX}) begin
      len = BURST_MAX;
    end else begin
      len = rem[4:0];
    end
    return len;
  endfunction

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  blen_q, blen_d;
  logic        busy_q, busy_d;
  logic        line_done_q, line_done_d;
  logic        underrun_q, underrun_d;
  logic [31:0] nla_q, nla_d;
  logic [11:0] word_rem_q, word_rem_d;
  logic [11:0] pend_q, pend_d;

  logic        trigger_s;
  logic [31:0] nla_src_s;
  logic        accept_s;
  logic        fetching_s;
  logic        rd_take_s;
  logic [11:0] pend_sum_s;
  logic [11:0] pend_next_s;
  logic [11:0] rem_after_s;

  // Line trigger and next-line address: eof rewinds to line 0, every trigger
  // (fetched or skipped) consumes one stride so the frame stays aligned.
  always_comb begin
    trigger_s = eol & next_vis & en;
    nla_src_s = eof ? pBaseAddr : nla_q;
    nla_d     = trigger_s ? (nla_src_s + STRIDE) : nla_src_s;
  end

  // Outstanding-word bookkeeping: a grant adds its burst, a returned word
  // removes one; a returned word with nothing outstanding is dropped.
  always_comb begin
    accept_s    = (state_q == ST_REQ) & req_q & ack;
    fetching_s  = (state_q == ST_REQ) | (state_q == ST_WAIT);
    pend_sum_s  = pend_q + (accept_s ? {7'd0, blen_q} : 12'd0);
    rd_take_s   = rd_vld & fetching_s & (pend_sum_s != 12'd0);
    pend_next_s = pend_sum_s - {11'd0, rd_take_s};
    rem_after_s = word_rem_q - {7'd0, blen_q};
  end

  // Fetch sequencing: next state and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    blen_d      = blen_q;
    busy_d      = busy_q;
    line_done_d = 1'b0;
    word_rem_d  = word_rem_q;
    pend_d      = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          state_d    = ST_REQ;
          req_d      = 1'b1;
          addr_d     = nla_src_s;
          blen_d     = burst_len_f(LINE_WORDS);
          word_rem_d = LINE_WORDS;
          pend_d     = 12'd0;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        pend_d = pend_next_s;
        if (accept_s) begin
          addr_d     = addr_q + ({27'd0, blen_q} * WORD_BYTES);
          word_rem_d = rem_after_s;
          blen_d     = burst_len_f(rem_after_s);
          if (rem_after_s == 12'd0) begin
            req_d   = 1'b0;
            state_d = ST_WAIT;
          end else begin
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end else begin
          // Arbiter stalled: hold address and length, keep asking.
          req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        pend_d = pend_next_s;
        if ((word_rem_q == 12'd0) && (pend_next_s == 12'd0)) begin
          state_d     = ST_DONE;
          line_done_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sticky underrun: a line arriving while a fetch is still active; a new
  // event outranks a clear in the same cycle.
  always_comb begin
    if (trigger_s && (state_q != ST_IDLE)) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      addr_q      <= 32'h0000_0000;
      blen_q      <= 5'd0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      nla_q       <= pBaseAddr;
      word_rem_q  <= 12'd0;
      pend_q      <= 12'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      blen_q      <= blen_d;
      busy_q      <= busy_d;
      line_done_q <= line_done_d;
      underrun_q  <= underrun_d;
      nla_q       <= nla_d;
      word_rem_q  <= word_rem_d;
      pend_q      <= pend_d;
    end
  end

  assign req       = req_q;
  assign addr      = addr_q;
  assign blen      = blen_q;
  assign busy      = busy_q;
  assign line_done = line_done_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_wxga_line_fetch_ctrl.sv
// tb_wxga_line_fetch_ctrl
// Drives directed and randomized line/burst traffic and compares the DUT every
// cycle against a line-level reference model: each line is expanded into its
// list of bursts up front, then tracked as "bursts granted" and "words still
// outstanding". A few literal expectations pin the model to known addresses.
module tb_wxga_line_fetch_ctrl;

  localparam logic [31:0] BASE       = 32'h0000_0000;
  localparam int          LINE_WORDS = 342;
  localparam int          BURST      = 16;
  localparam int          WORD_BYTES = 8;
  localparam int          STRIDE     = 2736;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, eol = 1'b0, eof = 1'b0, next_vis = 1'b0;
  logic        ack = 1'b0, rd_vld = 1'b0, clr_underrun = 1'b0;
  logic        req, busy, line_done, underrun;
  logic [31:0] addr;
  logic [4:0]  blen;

  int checks   = 0;
  int failures = 0;

  wxga_line_fetch_ctrl #(
    .pBaseAddr  (BASE),
    .pLineWords (LINE_WORDS),
    .pBurstLen  (BURST),
    .pWordBytes (WORD_BYTES),
    .pLineStride(STRIDE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .eol         (eol),
    .eof         (eof),
    .next_vis    (next_vis),
    .req         (req),
    .ack         (ack),
    .addr        (addr),
    .blen        (blen),
    .rd_vld      (rd_vld),
    .busy        (busy),
    .line_done   (line_done),
    .underrun    (underrun),
    .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid = 1'b0;
  bit          m_active, m_done, m_under;
  int          m_issued, m_outst;
  logic [31:0] m_nla;
  logic [31:0] m_baddr[$];
  int          m_blen[$];

  // granted bursts and line_done pulses seen on the DUT, for literal pins
  logic [31:0] obs_addr[$];
  int          obs_blen[$];
  int          obs_done = 0;

  task automatic model_reset();
    m_active = 1'b0; m_done = 1'b0; m_under = 1'b0;
    m_issued = 0; m_outst = 0; m_nla = BASE;
    m_baddr.delete(); m_blen.delete();
  endtask

  task automatic start_line(input logic [31:0] a0);
    int rem, l;
    logic [31:0] a;
    m_baddr.delete(); m_blen.delete();
    rem = LINE_WORDS; a = a0;
    while (rem > 0) begin
      l = (rem > BURST) ? BURST : rem;
      m_baddr.push_back(a);
      m_blen.push_back(l);
      a   = a + 32'(l * WORD_BYTES);
      rem = rem - l;
    end
    m_issued = 0; m_outst = 0; m_active = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    bit trig, idle, acc;
    logic [31:0] src;
    if (!rst) begin
      model_reset();
      m_valid = 1'b1;
      return;
    end
    trig  = eol && next_vis && en;
    idle  = !m_active && !m_done;
    src   = eof ? BASE : m_nla;
    m_nla = trig ? (src + 32'(STRIDE)) : src;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      acc = (m_issued < m_baddr.size()) && ack;
      if (acc) begin
        m_outst  = m_outst + m_blen[m_issued];
        m_issued = m_issued + 1;
      end
      if (rd_vld && m_outst > 0) m_outst = m_outst - 1;
      if (m_issued == m_baddr.size() && m_outst == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    if (trig && !idle) m_under = 1'b1;
    else if (clr_underrun) m_under = 1'b0;
    if (trig && idle) start_line(src);
  endtask

  // Compare process: outputs are checked on the falling edge, then the model
  // is stepped with the inputs that the next rising edge will sample.
  initial begin : compare_proc
    bit er;
    model_reset();
    forever begin
      @(negedge clk);
      if (m_valid) begin
        er = m_active && (m_issued < m_baddr.size());
        check("req", 32'(req), 32'(er));
        check("busy", 32'(busy), 32'(m_active || m_done));
        check("line_done", 32'(line_done), 32'(m_done));
        check("underrun", 32'(underrun), 32'(m_under));
        if (er) begin
          check("addr", addr, m_baddr[m_issued]);
          check("blen", 32'(blen), 32'(m_blen[m_issued]));
        end
        if (req && ack) begin
          obs_addr.push_back(addr);
          obs_blen.push_back(int'(blen));
        end
        if (line_done) obs_done++;
      end
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit f_eof, input bit f_vis);
    eol = 1'b1; eof = f_eof; next_vis = f_vis;
    tick();
    eol = 1'b0; eof = 1'b0; next_vis = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = line_done;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < obs_addr.size()) return obs_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int last_blen();
    if (obs_blen.size() > 0) return obs_blen[obs_blen.size() - 1];
    return -1;
  endfunction

  task automatic obs_clear();
    obs_addr.delete(); obs_blen.delete(); obs_done = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int period, ack_pct, rd_pct;
    bit vis, is_eof;

    repeat (3) tick();
    check("rst_req", 32'(req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_blen", 32'(blen), 32'd0);
    rst = 1'b1; en = 1'b1;
    tick();

    // Line 0 with eof, arbiter always granting, data every cycle
    ack = 1'b1; rd_vld = 1'b1;
    obs_clear();
    strobe(1'b1, 1'b1);
    wait_done("t1_done", 1000);
    tick(); tick();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_nbursts", 32'(obs_addr.size()), 32'd22);
    check("t1_addr0", q_at(0), 32'h0);
    check("t1_addr1", q_at(1), 32'h80);
    check("t1_addr21", q_at(21), 32'hA80);
    check("t1_last_blen", 32'(last_blen()), 32'd6);
    check("t1_done_pulses", 32'(obs_done), 32'd1);

    // Next line is one stride on; after an eof the address rewinds
    obs_clear();
    strobe(1'b0, 1'b1);
    wait_done("t2_done", 1000);
    tick();
    check("t2_addr0", q_at(0), 32'hAB0);
    strobe(1'b1, 1'b0);
    repeat (3) tick();
    obs_clear();
    strobe(1'b0, 1'b1);
    wait_done("t2b_done", 1000);
    tick();
    check("t2b_addr0", q_at(0), 32'h0);

    // Arbiter stalls the first request for several cycles
    ack = 1'b0;
    obs_clear();
    strobe(1'b0, 1'b1);
    repeat (5) tick();
    check("t3_req_held", 32'(req), 32'd1);
    check("t3_addr_held", addr, 32'hAB0);
    check("t3_blen_held", 32'(blen), 32'd16);
    ack = 1'b1;
    wait_done("t3_done", 1000);
    tick();
    check("t3_nbursts", 32'(obs_addr.size()), 32'd22);
    check("t3_addr21", q_at(21), 32'h1530);

    // Underrun: new line arrives while 10 words are still outstanding
    rd_vld = 1'b0;
    obs_clear();
    strobe(1'b0, 1'b1);
    repeat (25) tick();
    rd_vld = 1'b1;
    repeat (332) tick();
    rd_vld = 1'b0;
    repeat (2) tick();
    check("t4_busy_waiting", 32'(busy), 32'd1);
    strobe(1'b0, 1'b1);
    check("t4_underrun_set", 32'(underrun), 32'd1);
    rd_vld = 1'b1;
    wait_done("t4_done", 100);
    tick();
    check("t4_addr0", q_at(0), 32'h1560);
    check("t4_underrun_sticky", 32'(underrun), 32'd1);
    clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
    check("t4_underrun_clr", 32'(underrun), 32'd0);
    obs_clear();
    strobe(1'b0, 1'b1);
    repeat (3) tick();
    clr_underrun = 1'b1;
    strobe(1'b0, 1'b1);
    clr_underrun = 1'b0;
    check("t4_set_wins", 32'(underrun), 32'd1);
    wait_done("t4b_done", 1000);
    tick();
    check("t4b_addr0", q_at(0), 32'h2AC0);

    // Reset in the middle of a burst sequence, with underrun set
    ack = 1'b0;
    strobe(1'b0, 1'b1);
    ack = 1'b1;
    repeat (15) tick();
    ack = 1'b0;
    strobe(1'b0, 1'b1);
    check("t6_req_before", 32'(req), 32'd1);
    check("t6_underrun_before", 32'(underrun), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t6_req", 32'(req), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_underrun", 32'(underrun), 32'd0);
    ack = 1'b1; rd_vld = 1'b1;
    obs_clear();
    strobe(1'b0, 1'b1);
    wait_done("t6_done", 1000);
    tick();
    check("t6_addr0", q_at(0), BASE);

    // Randomized frames: varying line periods, grant/data rates, blanking
    for (int line = 0; line < 40; line++) begin
      period  = int'($urandom_range(700, 250));
      ack_pct = int'($urandom_range(100, 30));
      rd_pct  = int'($urandom_range(100, 60));
      vis     = ($urandom_range(9, 0) != 0);
      is_eof  = ((line % 8) == 7);
      en      = ($urandom_range(19, 0) != 0);
      strobe(is_eof, vis);
      for (int c = 1; c < period; c++) begin
        ack          = ($urandom_range(99, 0) < ack_pct);
        rd_vld       = ($urandom_range(99, 0) < rd_pct);
        clr_underrun = ($urandom_range(199, 0) == 0);
        rst          = ($urandom_range(4999, 0) != 0);
        tick();
      end
    end
    rst = 1'b1; clr_underrun = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
